seg7_scan_ctrl: RTL



---
 rtl/seg7_scan_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment display driver.
//   Scans NUM_DIGITS digits and holds each digit for SCAN_DIV clocks.
//   Display data is double-buffered: load captures it into a shadow register,
//   and the shadow is committed only at frame boundaries, so a frame never
//   shows a mix of old and new data.
//   Also provides per-digit decimal points and optional leading-zero blanking.
//
// Ports:
//   clk_g       system clock
//   rst_n       asynchronous active-low reset
//   busy        display suspend: scan halted, all digits off, shadow committed each cycle
//   disp_data   hex nibbles, digit k = disp_data[4k+3:4k]
//   dp_mask     bit k lights the decimal point of digit k
//   blank_lz    enable leading-zero suppression
//   load        one-cycle strobe capturing disp_data/dp_mask into the shadow
//   digit_en    digit enables (polarity per ACTIVE_LOW)
//   seg         {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
//   seg_dp      decimal point (polarity per ACTIVE_LOW)
//   frame_done  one-cycle pulse after the last digit's slot ends
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int DIV_W      = 17,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk_g,
  input  logic                    rst_n,
  input  logic                    busy,
  input  logic [4*NUM_DIGITS-1:0] disp_data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic             AL       = (ACTIVE_LOW != 0);

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow_data, disp_reg;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp;

  logic                  tick, boundary;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_lz, blank, all_zero;
  logic [NUM_DIGITS-1:0] lz_zero, en_lit;
  logic [6:0]            pat, seg_lit;

  assign tick     = (div_cnt == DIV_LAST);
  assign boundary = tick && (idx == IDX_LAST);

  // Prescaler, digit index and frame pulse
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else if (busy) begin
      div_cnt    <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (tick) begin
        div_cnt <= '0;
        idx     <= boundary ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Double buffer. A load arriving on the commit edge bypasses the shadow,
  // so the newest data is never skipped.
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      disp_reg    <= '0;
      disp_dp     <= '0;
    end else begin
      if (load) begin
        shadow_data <= disp_data;
        shadow_dp   <= dp_mask;
      end
      if (busy || boundary) begin
        disp_reg <= load ? disp_data : shadow_data;
        disp_dp  <= load ? dp_mask   : shadow_dp;
      end
    end
  end

  // lz_zero[k]: every displayed nibble from k up to the top digit is zero
  always_comb begin
    all_zero = 1'b1;
    lz_zero  = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      all_zero = all_zero & (disp_reg[4*(NUM_DIGITS-1-j) +: 4] == 4'd0);
      lz_zero[NUM_DIGITS-1-j] = all_zero;
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib = disp_reg[4*k +: 4];
        cur_dp  = disp_dp[k];
        cur_lz  = lz_zero[k];
      end
    end
  end

  always_comb begin
    case (cur_nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
  end

  assign blank   = blank_lz && (idx != '0) && cur_lz;
  assign seg_lit = blank ? 7'h00 : pat;
  assign en_lit  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

  // Enable and segments are registered together from the same idx/display
  // snapshot, so an enable never appears with the previous digit's segments.
  // XOR with the polarity mask converts active-high values to pin levels.
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      digit_en <= {NUM_DIGITS{AL}};
      seg      <= {7{AL}};
      seg_dp   <= AL;
    end else if (busy) begin
      digit_en <= {NUM_DIGITS{AL}};
      seg      <= {7{AL}};
      seg_dp   <= AL;
    end else begin
      digit_en <= en_lit ^ {NUM_DIGITS{AL}};
      seg      <= seg_lit ^ {7{AL}};
      seg_dp   <= cur_dp ^ AL;
    end
  end

endmodule
